ila_capture_ctrl: RTL and testbench
===================================

Name: ila_capture_ctrl

Overview:
Capture sequencer for the internal logic analyzer's sample buffer. Arms on request, pre-fills a circular sample RAM, and waits for a trigger once primed. After the trigger it writes a programmable number of post-trigger samples, then streams the whole buffer out, oldest sample first, over a valid/ready handshake. It drives the RAM write/read addresses; the analyzer datapath and the signal generator sit around it.

Parameters:
ADDR_WIDTH, 4, sample RAM address width; DEPTH = 2**ADDR_WIDTH entries
HOLDOFF_WIDTH, 8, width of the post-trigger sample count input

Ports:
clk  input  1  single clock, all logic rising-edge
reset  input  1  asynchronous, active-low; 0 forces reset state immediately
i_arm  input  1  start capture (honoured only in IDLE)
i_trigger  input  1  trigger qualifier (honoured only in PRIMED)
i_holdoff  input  HOLDOFF_WIDTH  post-trigger samples to write after the trigger sample
i_rd_ready  input  1  readout consumer ready
o_wr_en  output  1  RAM write enable
o_wr_addr  output  ADDR_WIDTH  RAM write address
o_rd_addr  output  ADDR_WIDTH  RAM read address (RAM read is combinational)
o_rd_valid  output  1  o_rd_addr valid for readout
o_rd_last  output  1  final readout beat
o_primed  output  1  buffer full, trigger accepted
o_triggered  output  1  trigger seen, capture not yet read out
o_done  output  1  one-cycle pulse: capture complete
o_trig_addr  output  ADDR_WIDTH  RAM address holding the trigger sample

Behaviour:
- Reset (reset=0): state IDLE; all outputs 0; internal counters 0.
- hold = min(i_holdoff, DEPTH-1). Sampled only in the trigger cycle; later changes are ignored.
- o_wr_en = 1 in FILL, PRIMED and POST, else 0.
- o_wr_addr increments by 1 after every write and wraps DEPTH-1 -> 0.
- IDLE:
  - i_arm=1 -> FILL; o_wr_addr and the fill counter clear to 0.
- FILL:
  - Writes DEPTH consecutive samples (addresses 0..DEPTH-1), then -> PRIMED.
  - i_trigger is ignored throughout.
- PRIMED:
  - o_primed=1; writes continue, wrapping.
  - i_trigger=1 marks the sample written that cycle as the trigger sample: o_trig_addr <= current o_wr_addr, o_triggered <= 1.
  - hold=0 -> DONE next cycle; otherwise load the post counter with hold and go to POST.
- POST:
  - One write per cycle; the counter decrements per write.
  - On the write with counter==1 -> DONE.
  - Exactly hold samples follow the trigger sample.
- DONE (1 cycle):
  - o_done=1, o_wr_en=0.
  - Read pointer <= o_wr_addr, which now points at the oldest sample.
  - -> READ.
- READ:
  - o_rd_valid=1 and o_rd_addr = read pointer.
  - Beat transfers when o_rd_valid & i_rd_ready; the pointer then advances by 1 with wrap.
  - o_rd_addr holds stable while valid & !ready.
  - Exactly DEPTH beats; o_rd_last=1 on the DEPTH-th.
  - After the last beat transfers -> IDLE; o_triggered and o_primed clear.
- o_primed=1 only in PRIMED.
- o_trig_addr holds its value until the next trigger.
- i_arm outside IDLE is ignored.
- Trigger and arm in the same cycle: each is judged by the current state only.
- Trigger position in readout: beat index (DEPTH-1-hold), counted from 0.
- Reset asserted mid-capture or mid-readout aborts immediately to IDLE with reset output values; buffer contents are undefined.

Optional Feature:
ILA_ABORT_EN
- Defined: adds port i_abort (input, 1). i_abort=1 in any non-IDLE state -> IDLE on the next clock edge. All outputs take their reset values except o_trig_addr, which is held. i_abort has priority over i_trigger and readout handshakes.
- Undefined: no i_abort port; a capture can be terminated only by reset.

Test Plan:
- Reset during FILL after 5 writes -> next cycle state IDLE, o_wr_en=0, o_wr_addr=0, all flags 0.
- DEPTH=16, i_arm pulse, trigger pulse 3 cycles before fill ends -> trigger ignored; o_primed rises after the 16th write (addresses 0..15); no o_done.
- Primed, i_holdoff=4, trigger while o_wr_addr=7 -> o_trig_addr=7, writes to 8..11, o_done pulse the cycle after write 11, readout starts at o_rd_addr=12, trigger sample on beat 11.
- i_holdoff=0, trigger at address 15 -> DONE next cycle, readout begins at address 0, trigger sample on beat 15, o_rd_last on beat 15.
- i_holdoff=200 -> clamped to 15; exactly 15 post-trigger writes; trigger sample on beat 0 of readout.
- Readout with i_rd_ready toggling 1,0,0,1,... -> o_rd_addr stable while stalled, exactly 16 transfers, return to IDLE after last; with ILA_ABORT_EN, i_abort mid-POST -> IDLE next cycle, o_trig_addr retained.

Source files
------------

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: capture sequencer for the internal logic analyzer.
// Arms on request and pre-fills a circular sample RAM. Once the RAM is full it
// waits for a trigger, then writes a programmable number of post-trigger
// samples. It then streams the buffer out, oldest sample first, over a
// valid/ready handshake.
// Optional feature macro: ILA_ABORT_EN adds an i_abort input. While the
// sequencer is busy, i_abort returns it to IDLE.

module ila_capture_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int HOLDOFF_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_arm,
    input  logic                     i_trigger,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    input  logic                     i_rd_ready,
`ifdef ILA_ABORT_EN
    input  logic                     i_abort,
`endif
    output logic                     o_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_wr_addr,
    output logic [ADDR_WIDTH-1:0]    o_rd_addr,
    output logic                     o_rd_valid,
    output logic                     o_rd_last,
    output logic                     o_primed,
    output logic                     o_triggered,
    output logic                     o_done,
    output logic [ADDR_WIDTH-1:0]    o_trig_addr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [HOLDOFF_WIDTH-1:0] MAX_HOLD  = HOLDOFF_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PRIMED,
        S_POST,
        S_DONE,
        S_READ
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] beat_cnt;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic                  triggered;
    logic [ADDR_WIDTH-1:0] hold;
    logic                  wr_en;
    logic                  beat_xfer;
    logic                  abort;

`ifdef ILA_ABORT_EN
    assign abort = i_abort && (state != S_IDLE);
`else
    assign abort = 1'b0;
`endif

    assign wr_en     = (state == S_FILL) || (state == S_PRIMED) || (state == S_POST);
    assign beat_xfer = (state == S_READ) && i_rd_ready;

    // Clamp the post-trigger count so the trigger sample itself always survives.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        hold = ADDR_WIDTH'(i_holdoff);
        if (i_holdoff > MAX_HOLD) begin
            hold = LAST_ADDR;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (i_arm) state_next = S_FILL;
            S_FILL:   if (fill_cnt == LAST_ADDR) state_next = S_PRIMED;
            S_PRIMED: if (i_trigger) state_next = (hold == '0) ? S_DONE : S_POST;
            S_POST:   if (post_cnt == ADDR_WIDTH'(1)) state_next = S_DONE;
            S_DONE:   state_next = S_READ;
            S_READ:   if (beat_xfer && (beat_cnt == LAST_ADDR)) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    // Address pointers, counters and trigger bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr   <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            rd_ptr    <= '0;
            beat_cnt  <= '0;
            trig_addr <= '0;
            triggered <= 1'b0;
        end else if (abort) begin
            // The trigger address is deliberately kept for post-mortem inspection.
            wr_addr   <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            rd_ptr    <= '0;
            beat_cnt  <= '0;
            triggered <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
            case (state)
                S_IDLE: begin
                    if (i_arm) begin
                        wr_addr  <= '0;
                        fill_cnt <= '0;
                    end
                end
                S_FILL: begin
                    fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
                end
                S_PRIMED: begin
                    if (i_trigger) begin
                        trig_addr <= wr_addr;
                        triggered <= 1'b1;
                        post_cnt  <= hold;
                    end
                end
                S_POST: begin
                    post_cnt <= post_cnt - ADDR_WIDTH'(1);
                end
                S_DONE: begin
                    // The write pointer has just moved past the newest sample,
                    // so it now addresses the oldest one.
                    rd_ptr   <= wr_addr;
                    beat_cnt <= '0;
                end
                S_READ: begin
                    if (beat_xfer) begin
                        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                        beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
                        if (beat_cnt == LAST_ADDR) begin
                            triggered <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_wr_en     = wr_en;
    assign o_wr_addr   = wr_addr;
    assign o_rd_addr   = rd_ptr;
    assign o_rd_valid  = (state == S_READ);
    assign o_rd_last   = (state == S_READ) && (beat_cnt == LAST_ADDR);
    assign o_primed    = (state == S_PRIMED);
    assign o_triggered = triggered;
    assign o_done      = (state == S_DONE);
    assign o_trig_addr = trig_addr;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed testbench for ila_capture_ctrl (DEPTH = 16, HOLDOFF_WIDTH = 8).
// Build with ILA_ABORT_EN defined to include the abort scenario.

module tb_ila_capture_ctrl;

    localparam int AW    = 4;
    localparam int HW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_arm;
    logic          i_trigger;
    logic [HW-1:0] i_holdoff;
    logic          i_rd_ready;
`ifdef ILA_ABORT_EN
    logic          i_abort;
`endif
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [AW-1:0] o_rd_addr;
    logic          o_rd_valid;
    logic          o_rd_last;
    logic          o_primed;
    logic          o_triggered;
    logic          o_done;
    logic [AW-1:0] o_trig_addr;

    int n_asserts = 0;
    int n_fail    = 0;

    ila_capture_ctrl #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_arm       (i_arm),
        .i_trigger   (i_trigger),
        .i_holdoff   (i_holdoff),
        .i_rd_ready  (i_rd_ready),
`ifdef ILA_ABORT_EN
        .i_abort     (i_abort),
`endif
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_rd_addr   (o_rd_addr),
        .o_rd_valid  (o_rd_valid),
        .o_rd_last   (o_rd_last),
        .o_primed    (o_primed),
        .o_triggered (o_triggered),
        .o_done      (o_done),
        .o_trig_addr (o_trig_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_flags(input string tag);
        check({tag, " wr_en"},     o_wr_en,     1'b0);
        check({tag, " primed"},    o_primed,    1'b0);
        check({tag, " triggered"}, o_triggered, 1'b0);
        check({tag, " done"},      o_done,      1'b0);
        check({tag, " rd_valid"},  o_rd_valid,  1'b0);
        check({tag, " rd_last"},   o_rd_last,   1'b0);
    endtask

    // Arm and write the 16 pre-fill samples; leaves the DUT in PRIMED at wr_addr 0.
    task automatic arm_and_fill();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        repeat (DEPTH) tick();
    endtask

    // Drain the readout with ready held high, starting from a given address.
    task automatic drain(input string tag, input int start, input int trig_beat);
        for (int b = 0; b < DEPTH; b++) begin
            check({tag, " rd_valid"}, o_rd_valid, 1'b1);
            check({tag, " rd_addr"},  o_rd_addr,  32'((start + b) % DEPTH));
            check({tag, " rd_last"},  o_rd_last,  (b == DEPTH - 1));
            if (b == trig_beat) check({tag, " trig beat"}, o_rd_addr, o_trig_addr);
            tick();
        end
        check({tag, " end rd_valid"},  o_rd_valid,  1'b0);
        check({tag, " end triggered"}, o_triggered, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        i_arm      = 1'b0;
        i_trigger  = 1'b0;
        i_holdoff  = '0;
        i_rd_ready = 1'b0;
`ifdef ILA_ABORT_EN
        i_abort    = 1'b0;
`endif

        // Reset state.
        repeat (3) tick();
        check_idle_flags("reset");
        check("reset wr_addr",   o_wr_addr,   0);
        check("reset rd_addr",   o_rd_addr,   0);
        check("reset trig_addr", o_trig_addr, 0);
        reset = 1'b1;
        tick();

        // Reset during FILL after 5 writes.
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        check("fill0 wr_en",   o_wr_en,   1'b1);
        check("fill0 wr_addr", o_wr_addr, 0);
        repeat (5) tick();
        check("fill5 wr_addr", o_wr_addr, 5);
        reset = 1'b0;
        #1;
        check("async reset wr_en", o_wr_en, 1'b0);
        tick();
        check_idle_flags("mid-fill reset");
        check("mid-fill reset wr_addr", o_wr_addr, 0);
        reset = 1'b1;
        tick();
        check("idle stays idle", o_wr_en, 1'b0);

        // Full fill, with a trigger 3 cycles before the end that must be ignored.
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("fill wr_en",   o_wr_en,   1'b1);
            check("fill wr_addr", o_wr_addr, i);
            check("fill primed",  o_primed,  1'b0);
            i_trigger = (i == DEPTH - 3);
            tick();
        end
        i_trigger = 1'b0;
        check("primed flag",      o_primed,    1'b1);
        check("primed wr_addr",   o_wr_addr,   0);
        check("primed triggered", o_triggered, 1'b0);
        check("primed done",      o_done,      1'b0);

        // Arm while primed is ignored; writes keep going.
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        check("arm ignored wr_addr", o_wr_addr, 1);
        check("arm ignored primed",  o_primed,  1'b1);

        // Trigger at wr_addr 7 with holdoff 4.
        repeat (6) tick();
        check("pre-trig wr_addr", o_wr_addr, 7);
        i_holdoff = 8'd4;
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        i_holdoff = 8'd9;
        check("h4 trig_addr", o_trig_addr, 7);
        check("h4 triggered", o_triggered, 1'b1);
        check("h4 primed",    o_primed,    1'b0);
        for (int a = 8; a <= 11; a++) begin
            check("h4 post wr_en",   o_wr_en,   1'b1);
            check("h4 post wr_addr", o_wr_addr, a);
            check("h4 post done",    o_done,    1'b0);
            tick();
        end
        check("h4 done",       o_done,    1'b1);
        check("h4 done wr_en", o_wr_en,   1'b0);
        check("h4 done addr",  o_wr_addr, 12);
        tick();
        i_rd_ready = 1'b1;
        drain("h4 read", 12, 11);
        i_rd_ready = 1'b0;

        // Holdoff 0, trigger at address 15, stalled readout 1,0,0,...
        arm_and_fill();
        repeat (15) tick();
        check("h0 pre-trig wr_addr", o_wr_addr, 15);
        i_holdoff = 8'd0;
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        check("h0 done",      o_done,      1'b1);
        check("h0 trig_addr", o_trig_addr, 15);
        check("h0 wr_en",     o_wr_en,     1'b0);
        tick();
        begin
            int beats = 0;
            for (int cyc = 0; cyc < 100 && beats < DEPTH; cyc++) begin
                i_rd_ready = ((cyc % 3) == 0);
                check("h0 rd_valid", o_rd_valid, 1'b1);
                check("h0 rd_addr",  o_rd_addr,  32'(beats % DEPTH));
                check("h0 rd_last",  o_rd_last,  (beats == DEPTH - 1));
                if (i_rd_ready) beats++;
                tick();
            end
            check("h0 beat count", 32'(beats), DEPTH);
        end
        i_rd_ready = 1'b0;
        check("h0 end rd_valid",  o_rd_valid,  1'b0);
        check("h0 end triggered", o_triggered, 1'b0);
        check("h0 trig_addr held", o_trig_addr, 15);

        // Holdoff 200 clamps to 15; arm and trigger together in IDLE.
        i_arm = 1'b1;
        i_trigger = 1'b1;
        tick();
        i_arm = 1'b0;
        i_trigger = 1'b0;
        check("arm+trig triggered", o_triggered, 1'b0);
        repeat (DEPTH) tick();
        i_holdoff = 8'd200;
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        check("h200 trig_addr", o_trig_addr, 0);
        for (int k = 1; k < DEPTH; k++) begin
            check("h200 post wr_en",   o_wr_en,   1'b1);
            check("h200 post wr_addr", o_wr_addr, k);
            check("h200 post done",    o_done,    1'b0);
            tick();
        end
        check("h200 done",      o_done,    1'b1);
        check("h200 done addr", o_wr_addr, 0);
        tick();
        i_rd_ready = 1'b1;
        drain("h200 read", 0, 0);
        i_rd_ready = 1'b0;

`ifdef ILA_ABORT_EN
        // Abort mid-POST.
        arm_and_fill();
        repeat (3) tick();
        i_holdoff = 8'd8;
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        tick();
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_idle_flags("abort");
        check("abort wr_addr",   o_wr_addr,   0);
        check("abort trig_addr", o_trig_addr, 3);
        tick();
        check("abort stays idle", o_wr_en, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
